// File: rtl/level_alarm_classifier.sv
// Level alarm classifier: turns filtered level samples into the 3-bit alarm code
// (OK/LOW/HIGH/ERROR), with hysteresis, debounce and range/config/timeout fault detection.
module level_alarm_classifier #(
    parameter int W         = 8,
    parameter int DEBOUNCE  = 4,
    parameter int HYST      = 2,
    parameter int MAX_VALID = 250,
    parameter int TIMEOUT   = 1000000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         sample_valid,
    input  logic [W-1:0] level,
    input  logic [W-1:0] low_thr,
    input  logic [W-1:0] high_thr,
    output logic [2:0]   alarm_code,
    output logic         alarm_change,
    output logic [1:0]   err_cause
);

    localparam int CW  = $clog2(DEBOUNCE + 1);
    localparam int TW  = $clog2(TIMEOUT);
    localparam int WP1 = W + 1;

    localparam logic [CW-1:0]  DEB_C   = CW'(DEBOUNCE);
    localparam logic [TW-1:0]  TMO_MAX = TW'(TIMEOUT - 1);
    localparam logic [WP1-1:0] HYST_E  = WP1'(HYST);
    localparam logic [WP1-1:0] MAXV_E  = WP1'(MAX_VALID);

    localparam logic [1:0] CAUSE_NONE  = 2'b00;
    localparam logic [1:0] CAUSE_RANGE = 2'b01;
    localparam logic [1:0] CAUSE_TMO   = 2'b10;
    localparam logic [1:0] CAUSE_CFG   = 2'b11;

    typedef enum logic [1:0] {
        S_OK   = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2,
        S_ERR  = 2'd3
    } state_e;

    function automatic logic [2:0] state_code(input state_e s);
        case (s)
            S_OK:    state_code = 3'b000;
            S_LOW:   state_code = 3'b001;
            S_HIGH:  state_code = 3'b010;
            default: state_code = 3'b100;
        endcase
    endfunction

    // Error causes rank config > range > timeout; none ranks lowest.
    function automatic logic [1:0] cause_rank(input logic [1:0] c);
        case (c)
            CAUSE_CFG:   cause_rank = 2'd3;
            CAUSE_RANGE: cause_rank = 2'd2;
            CAUSE_TMO:   cause_rank = 2'd1;
            default:     cause_rank = 2'd0;
        endcase
    endfunction

    function automatic logic [WP1-1:0] sat_sub(input logic [WP1-1:0] a, input logic [WP1-1:0] b);
        sat_sub = (a >= b) ? (a - b) : '0;
    endfunction

    state_e         state_q, state_d, pend_q, pend_d, desired;
    logic [CW-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic [1:0]     cause_q, cause_d, fault_cause;
    logic [2:0]     code_q, code_d;
    logic           change_q;
    logic           cfg_err, rng_err, tmo_err, fault;
    logic [WP1-1:0] low_hyst, high_hyst;

    // Desired state from the current sample; the exit bands are widened by HYST.
    always_comb begin
        low_hyst  = {1'b0, low_thr} + HYST_E;
        high_hyst = sat_sub({1'b0, high_thr}, HYST_E);
        desired   = S_OK;
        case (state_q)
            S_OK: begin
                if (level < low_thr)       desired = S_LOW;
                else if (level > high_thr) desired = S_HIGH;
                else                       desired = S_OK;
            end
            S_LOW: begin
                if (level > high_thr)                  desired = S_HIGH;
                else if ({1'b0, level} >= low_hyst)    desired = S_OK;
                else                                   desired = S_LOW;
            end
            S_HIGH: begin
                if (level < low_thr)                   desired = S_LOW;
                else if ({1'b0, level} <= high_hyst)   desired = S_OK;
                else                                   desired = S_HIGH;
            end
            default: desired = S_OK;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        cause_d = cause_q;

        cfg_err = (low_thr >= high_thr);
        rng_err = sample_valid && ({1'b0, level} > MAXV_E);
        tmo_err = !sample_valid && (tmo_q == TMO_MAX);
        fault   = cfg_err || rng_err || tmo_err;

        if (cfg_err)      fault_cause = CAUSE_CFG;
        else if (rng_err) fault_cause = CAUSE_RANGE;
        else if (tmo_err) fault_cause = CAUSE_TMO;
        else              fault_cause = CAUSE_NONE;

        if (sample_valid)          tmo_d = '0;
        else if (tmo_q == TMO_MAX) tmo_d = tmo_q;
        else                       tmo_d = tmo_q + TW'(1);

        // In ERROR every clean sample extends the exit run; otherwise the run tracks pending.
        if (state_q == S_ERR || desired == pend_q) cnt_inc = cnt_q + CW'(1);
        else                                       cnt_inc = CW'(1);

        if (fault) begin
            if (state_q != S_ERR) begin
                state_d = S_ERR;
                cause_d = fault_cause;
                cnt_d   = '0;
                pend_d  = S_OK;
            end else begin
                if (cause_rank(fault_cause) > cause_rank(cause_q)) cause_d = fault_cause;
                if (cfg_err || rng_err) cnt_d = '0;
            end
        end else if (sample_valid) begin
            if (state_q == S_ERR) begin
                if (cnt_inc == DEB_C) begin
                    state_d = S_OK;
                    pend_d  = S_OK;
                    cnt_d   = '0;
                    cause_d = CAUSE_NONE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end else if (desired == state_q) begin
                cnt_d = '0;
            end else begin
                pend_d = desired;
                if (cnt_inc == DEB_C) begin
                    state_d = desired;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
        end

        code_d = state_code(state_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_OK;
            pend_q   <= S_OK;
            cnt_q    <= '0;
            tmo_q    <= '0;
            cause_q  <= CAUSE_NONE;
            code_q   <= 3'b000;
            change_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            cnt_q    <= cnt_d;
            tmo_q    <= tmo_d;
            cause_q  <= cause_d;
            code_q   <= code_d;
            change_q <= (code_d != code_q);
        end
    end

    assign alarm_code   = code_q;
    assign alarm_change = change_q;
    assign err_cause    = cause_q;

endmodule

// File: tb/tb_level_alarm_classifier.sv
// Bench for level_alarm_classifier: directed scenarios plus randomized traffic,
// each cycle compared against a behavioural model of the alarm rules.
module tb_level_alarm_classifier;

    localparam int DEB  = 3;
    localparam int TMO  = 16;
    localparam int MAXV = 250;
    localparam int HYS  = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       sv;
    logic [7:0] slv;
    logic [7:0] lo, hi;
    logic [2:0] alarm_code;
    logic       alarm_change;
    logic [1:0] err_cause;

    int n_checks = 0;
    int n_fail   = 0;
    int n_chg    = 0;

    // Model state: alarm code value (0 OK, 1 LOW, 2 HIGH, 4 ERROR) and bookkeeping.
    int m_code = 0, m_cause = 0, m_pend = 0, m_cnt = 0, m_idle = 0, m_chg = 0;

    level_alarm_classifier #(
        .W(8), .DEBOUNCE(DEB), .HYST(HYS), .MAX_VALID(MAXV), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset(rst), .sample_valid(sv), .level(slv),
        .low_thr(lo), .high_thr(hi),
        .alarm_code(alarm_code), .alarm_change(alarm_change), .err_cause(err_cause)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int rank(input int c);
        return (c == 3) ? 3 : (c == 1) ? 2 : (c == 2) ? 1 : 0;
    endfunction

    function automatic int want(input int cur, input int lv, input int l, input int h);
        int hm;
        hm = (h - HYS < 0) ? 0 : h - HYS;
        if (cur == 0) return (lv < l) ? 1 : (lv > h) ? 2 : 0;
        if (cur == 1) return (lv > h) ? 2 : (lv >= l + HYS) ? 0 : 1;
        return (lv < l) ? 1 : (lv <= hm) ? 0 : 2;
    endfunction

    task automatic model_step(input bit v, input int lv);
        int prev, d, cn, l, h;
        bit cfg, rng, tmo;
        if (rst) begin
            m_code = 0; m_cause = 0; m_pend = 0; m_cnt = 0; m_idle = 0; m_chg = 0;
            return;
        end
        l = int'(lo);
        h = int'(hi);
        prev = m_code;
        cfg = (l >= h);
        rng = v && (lv > MAXV);
        tmo = !v && (m_idle == TMO - 1);
        m_idle = v ? 0 : ((m_idle < TMO - 1) ? m_idle + 1 : m_idle);
        if (cfg || rng || tmo) begin
            cn = cfg ? 3 : (rng ? 1 : 2);
            if (m_code != 4) begin
                m_code = 4; m_cause = cn; m_cnt = 0; m_pend = 0;
            end else begin
                if (rank(cn) > rank(m_cause)) m_cause = cn;
                if (cfg || rng) m_cnt = 0;
            end
        end else if (v) begin
            if (m_code == 4) begin
                m_cnt++;
                if (m_cnt == DEB) begin
                    m_code = 0; m_cause = 0; m_cnt = 0; m_pend = 0;
                end
            end else begin
                d = want(m_code, lv, l, h);
                if (d == m_code) m_cnt = 0;
                else if (d == m_pend) m_cnt++;
                else begin
                    m_pend = d; m_cnt = 1;
                end
                if (m_cnt == DEB) begin
                    m_code = d; m_cnt = 0;
                end
            end
        end
        m_chg = (m_code != prev) ? 1 : 0;
    endtask

    task automatic cyc(input bit v, input int lvl);
        sv  = v;
        slv = 8'(lvl);
        @(posedge clk);
        model_step(v, lvl);
        #1;
        chk("code", int'(alarm_code), m_code);
        chk("chg", int'(alarm_change), m_chg);
        chk("cause", int'(err_cause), m_cause);
        if (alarm_change) n_chg++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(0, 0);
        rst = 1'b0;
    endtask

    task automatic samples(input int n, input int lvl);
        for (int i = 0; i < n; i++) cyc(1, lvl);
    endtask

    task automatic idles(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0);
    endtask

    function automatic int clamp8(input int x);
        return (x < 0) ? 0 : (x > 255) ? 255 : x;
    endfunction

    initial begin
        int c0, r, x;
        rst = 1'b1; sv = 1'b0; slv = '0; lo = 8'd20; hi = 8'd200;

        // Reset state
        do_reset();
        chk("rst_code", int'(alarm_code), 0);
        chk("rst_chg", int'(alarm_change), 0);
        chk("rst_cause", int'(err_cause), 0);

        // 1: debounce across idle gaps
        c0 = n_chg;
        cyc(1, 10); idles(2); cyc(1, 10); idles(3);
        chk("s1_before", int'(alarm_code), 0);
        cyc(1, 10);
        chk("s1_low", int'(alarm_code), 1);
        chk("s1_pulse", int'(alarm_change), 1);
        idles(2);
        chk("s1_npulse", n_chg - c0, 1);
        do_reset();
        samples(2, 10); cyc(1, 100);
        chk("s1_broken", int'(alarm_code), 0);
        cyc(1, 10);
        chk("s1_restart", int'(alarm_code), 0);

        // 2: LOW-side hysteresis
        do_reset();
        samples(3, 10);
        samples(3, 21);
        chk("s2_hold", int'(alarm_code), 1);
        samples(3, 22);
        chk("s2_ok", int'(alarm_code), 0);

        // 3: HIGH-side hysteresis and direct LOW->HIGH
        do_reset();
        samples(3, 201);
        chk("s3_high", int'(alarm_code), 2);
        samples(3, 199);
        chk("s3_hold", int'(alarm_code), 2);
        samples(3, 198);
        chk("s3_ok", int'(alarm_code), 0);
        samples(3, 10);
        chk("s3_low", int'(alarm_code), 1);
        samples(3, 230);
        chk("s3_direct", int'(alarm_code), 2);

        // 4: range error and recovery
        do_reset();
        cyc(1, 251);
        chk("s4_err", int'(alarm_code), 4);
        chk("s4_cause", int'(err_cause), 1);
        samples(2, 100); cyc(1, 255); samples(2, 100);
        chk("s4_still", int'(alarm_code), 4);
        cyc(1, 100);
        chk("s4_exit", int'(alarm_code), 0);
        chk("s4_clr", int'(err_cause), 0);

        // 5: timeout boundary
        do_reset();
        idles(15);
        chk("s5_pre", int'(alarm_code), 0);
        cyc(0, 0);
        chk("s5_tmo", int'(alarm_code), 4);
        chk("s5_cause", int'(err_cause), 2);
        do_reset();
        idles(14); cyc(1, 100); idles(10);
        chk("s5_noerr", int'(alarm_code), 0);
        do_reset();
        idles(15); cyc(1, 100);
        chk("s5_samewin", int'(alarm_code), 0);

        // 6: config error overrides timeout; reset mid-run
        do_reset();
        idles(15);
        lo = 8'd200; hi = 8'd20;
        cyc(0, 0);
        chk("s6_err", int'(alarm_code), 4);
        chk("s6_cause", int'(err_cause), 3);
        lo = 8'd20; hi = 8'd200;
        samples(2, 100);
        chk("s6_still", int'(alarm_code), 4);
        cyc(1, 100);
        chk("s6_exit", int'(alarm_code), 0);
        samples(2, 10);
        do_reset();
        samples(2, 10);
        chk("s6_fresh", int'(alarm_code), 0);
        cyc(1, 10);
        chk("s6_low", int'(alarm_code), 1);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 199);
            if (r < 2) begin
                do_reset();
            end else if (r < 6) begin
                lo = 8'($urandom_range(0, 120));
                hi = 8'($urandom_range(60, 255));
                cyc(0, 0);
            end else if (r < 9) begin
                idles($urandom_range(10, 20));
            end else if ($urandom_range(0, 9) < 7) begin
                case ($urandom_range(0, 9))
                    0: x = int'(lo) - 1;
                    1: x = int'(lo);
                    2: x = int'(lo) + 1;
                    3: x = int'(lo) + 2;
                    4: x = int'(hi) - 2;
                    5: x = int'(hi) - 1;
                    6: x = int'(hi);
                    7: x = int'(hi) + 1;
                    8: x = int'($urandom_range(0, 250));
                    default: x = int'($urandom_range(240, 255));
                endcase
                cyc(1, clamp8(x));
            end else begin
                cyc(0, 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/level_alarm_classifier.md
Name: level_alarm_classifier

Overview:
Sits upstream of the 7-segment alarm letter driver and produces its 3-bit alarm code from the filtered liquid-level samples. Compares each level sample against programmable low and high thresholds, with hysteresis and consecutive-sample debounce. Also raises an ERROR code for out-of-range samples, misconfigured thresholds, or a sample-stream timeout. Alarm code encoding: 000 OK, 001 LOW, 010 HIGH, 100 ERROR. No other values are ever driven.

Parameters:
W, 8, level/threshold width in bits
DEBOUNCE, 4, consecutive valid samples needed to change state (>=1)
HYST, 2, hysteresis band in level LSBs
MAX_VALID, 250, largest legal level value; any larger value is a range error
TIMEOUT, 1000000, clock cycles without sample_valid before a timeout error (>=2)

Ports:
clk  input  1  system clock
reset  input  1  reset, synchronous, active-high
sample_valid  input  1  level qualifies this cycle
level  input  W  level sample
low_thr  input  W  LOW entry threshold, quasi-static
high_thr  input  W  HIGH entry threshold, quasi-static
alarm_code  output  3  registered alarm code for the display stage
alarm_change  output  1  one-cycle pulse when alarm_code changes
err_cause  output  2  00 none, 01 range, 10 timeout, 11 config; valid while alarm_code=100

Behaviour:
- Reset (sync, wins over everything): state OK, alarm_code=000, alarm_change=0, err_cause=00, debounce count=0, pending=OK, timeout counter=0.
- States: OK, LOW, HIGH, ERROR. alarm_code is a registered decode of the state.
- Config error: low_thr >= high_thr. Checked every cycle. Forces ERROR with err_cause=11 on the next edge, with no debounce.
- Range error: sample_valid=1 and level > MAX_VALID. Forces ERROR with err_cause=01 on that edge, with no debounce.
- Timeout counter: cleared on every sample_valid cycle, otherwise increments and saturates. When it reaches TIMEOUT-1 with no sample, it forces ERROR with err_cause=10 on that edge. If sample_valid arrives on the same cycle, the sample wins and no timeout occurs.
- Error priority for simultaneous causes: config > range > timeout. A higher-priority cause arriving while already in ERROR updates err_cause.
- Desired state D, evaluated per valid in-range sample with good config:
  - From OK: D=LOW if level < low_thr; D=HIGH if level > high_thr; else OK.
  - From LOW: D=HIGH if level > high_thr; D=OK if level >= low_thr+HYST; else LOW.
  - From HIGH: D=LOW if level < low_thr; D=OK if level <= high_thr-HYST; else HIGH.
  - low_thr+HYST is computed in W+1 bits (no wrap). high_thr-HYST saturates at 0.
- Debounce:
  - D == current state: count=0.
  - D == pending: count increments.
  - D differs from pending: pending=D, count=1.
  - When count reaches DEBOUNCE, the state moves to D on that edge and count clears. With DEBOUNCE=1 a single sample transitions.
  - Cycles with sample_valid=0 neither advance nor break a run.
- ERROR exit: requires DEBOUNCE consecutive valid in-range samples with good config. Exit is always to OK; normal evaluation resumes with the next sample. Any range or config fault during the run restarts it. On exit, err_cause returns to 00.
- Latency: alarm_code is visible the cycle after the edge that consumes the deciding sample. alarm_change pulses in that same cycle, and only if the code value actually changed.
- Threshold changes mid-run take effect on the next sample; the debounce run is not reset.

Test Plan:
Setup for all scenarios: W=8, DEBOUNCE=3, HYST=2, MAX_VALID=250, TIMEOUT=16, low_thr=20, high_thr=200.
1. Debounce with gaps: level 10 on 3 valid samples, idle cycles between them -> alarm_code 001 after the 3rd sample; alarm_change pulses once. Two samples of 10 then one of 100 -> stays 000.
2. Hysteresis on the LOW side: from LOW, 3 samples of 21 -> stays 001; then 3 samples of 22 -> 000.
3. Hysteresis and direct transition on the HIGH side: from OK, 3 samples of 201 -> 010; then 3 samples of 199 -> stays 010; then 3 samples of 198 -> 000. From LOW, 3 samples of 230 -> 010 directly.
4. Range error and recovery: one sample of 251 -> next cycle alarm_code 100, err_cause 01. Then 2 samples of 100, one of 255, then 3 samples of 100 -> exits to 000 only after the final 3.
5. Timeout: 16 cycles with sample_valid=0 -> 100, err_cause 10. In a separate run, a sample on cycle 15 -> no error.
6. Config error and reset: set low_thr=200, high_thr=20 -> 100, err_cause 11 the next cycle, overriding a concurrent timeout. Assert reset mid-debounce run -> 000, counters cleared, a fresh 3 samples needed.
